// File: rtl/kmcintr_pkg.sv
// rtl/kmcintr_pkg.sv - shared types and constants for the KMC11 interrupt requester
package kmcintr_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [2:0] VECT0 = 3'd0;
  localparam logic [2:0] VECT4 = 3'd4;
  localparam int BR_W = 4;

  // devINTR covers BR7..BR4; bit 0 corresponds to BR4
  function automatic logic [BR_W-1:0] brMask(input int level);
    brMask = {{(BR_W-1){1'b0}}, 1'b1} << (level - 4);
  endfunction

endpackage

// File: rtl/kmc_intr_ctl_if.sv
// rtl/kmc_intr_ctl_if.sv - MISC-register trigger and UBA interrupt handshake bundle
interface kmc_intr_ctl_if;
  import kmcintr_pkg::*;

  logic            kmcINIT;
  logic            kmcSETIRQ;
  logic            kmcVECTXXX4;
  logic            devINTA;
  logic [BR_W-1:0] devINTR;
  logic [15:0]     devVECT;
  logic            devVACK;
  logic            kmcIRQO;
  logic            kmcINTTMO;

  modport master (
    output kmcINIT, kmcSETIRQ, kmcVECTXXX4, devINTA,
    input  devINTR, devVECT, devVACK, kmcIRQO, kmcINTTMO
  );

  modport slave (
    input  kmcINIT, kmcSETIRQ, kmcVECTXXX4, devINTA,
    output devINTR, devVECT, devVACK, kmcIRQO, kmcINTTMO
  );
endinterface

// File: rtl/kmc_intr_tmo.sv
// rtl/kmc_intr_tmo.sv - acknowledge timeout counter, used only with KMCINTR_TIMEOUT_EN
module kmc_intr_tmo #(
  parameter int CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);
  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
  // Loading CYC-1 makes the request stay up for exactly CYC cycles
  localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/kmc_intr_ctl.sv
// rtl/kmc_intr_ctl.sv - KMC11 Unibus interrupt requester; ack timeout under KMCINTR_TIMEOUT_EN
import kmcintr_pkg::*;

module kmc_intr_ctl #(
  parameter logic [15:0] VECT_BASE = 16'o000540,
  parameter int          BR_LEVEL  = 5,
  parameter int          TMO_CYC   = 4096
) (
  input logic           clk,
  input logic           rst,
  kmc_intr_ctl_if.slave bus
);

  if (VECT_BASE[2:0] != 3'b000) begin : gBadBase
    $error("VECT_BASE must be a multiple of 8");
  end
  if ((BR_LEVEL < 4) || (BR_LEVEL > 7)) begin : gBadLevel
    $error("BR_LEVEL must be 4..7");
  end
  if (TMO_CYC < 1) begin : gBadTmo
    $error("TMO_CYC must be at least 1");
  end

  state_t          state;
  logic            pend0, pend4;
  logic [BR_W-1:0] intrQ;
  logic [15:0]     vectQ;
  logic            vackQ;
  logic            tmoQ;

  logic reset, anyPend, ackHit, enterReq, expire, tmoDrop;
  logic set0, set4, clr0, clr4;

  assign reset    = rst | bus.kmcINIT;
  assign anyPend  = pend0 | pend4;
  assign ackHit   = (state == REQ) && bus.devINTA;
  assign enterReq = (state != REQ) && anyPend;
  assign tmoDrop  = (state == REQ) && expire && !bus.devINTA;

  assign set0 = bus.kmcSETIRQ && !bus.kmcVECTXXX4;
  assign set4 = bus.kmcSETIRQ && bus.kmcVECTXXX4;
  // base+0 wins arbitration, so only one flag is cleared per acknowledge
  assign clr0 = (ackHit && pend0) || tmoDrop;
  assign clr4 = (ackHit && !pend0) || tmoDrop;

`ifdef KMCINTR_TIMEOUT_EN
  kmc_intr_tmo #(.CYC(TMO_CYC)) uTmo (
    .clk    (clk),
    .rst    (reset),
    .load   (enterReq),
    .dec    (state == REQ),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) tmoQ <= 1'b0;
    else if (tmoDrop) tmoQ <= 1'b1;
  end
`else
  assign expire = 1'b0;
  assign tmoQ   = 1'b0;
`endif

  // A new trigger on the same cycle its flag is cleared keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      pend0 <= 1'b0;
      pend4 <= 1'b0;
    end else begin
      pend0 <= (pend0 && !clr0) || set0;
      pend4 <= (pend4 && !clr4) || set4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      intrQ <= '0;
      vectQ <= '0;
      vackQ <= 1'b0;
    end else begin
      vackQ <= 1'b0;
      vectQ <= '0;
      case (state)
        IDLE: begin
          if (anyPend) begin
            state <= REQ;
            intrQ <= brMask(BR_LEVEL);
          end
        end
        REQ: begin
          if (ackHit) begin
            state <= GAP;
            intrQ <= '0;
            vackQ <= 1'b1;
            vectQ <= VECT_BASE + {13'd0, (pend0 ? VECT0 : VECT4)};
          end else if (tmoDrop) begin
            state <= IDLE;
            intrQ <= '0;
          end
        end
        GAP: begin
          if (anyPend) begin
            state <= REQ;
            intrQ <= brMask(BR_LEVEL);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          intrQ <= '0;
        end
      endcase
    end
  end

  assign bus.devINTR   = intrQ;
  assign bus.devVECT   = vectQ;
  assign bus.devVACK   = vackQ;
  assign bus.kmcINTTMO = tmoQ;
  assign bus.kmcIRQO   = anyPend || (state != IDLE);

endmodule

// File: tb/tb_kmc_intr_ctl.sv
// tb/tb_kmc_intr_ctl.sv - directed self-checking bench for kmc_intr_ctl
module tb_kmc_intr_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   hiCnt;

  always #5 clk = ~clk;

  kmc_intr_ctl_if bus ();

  kmc_intr_ctl #(
    .VECT_BASE (16'o000540),
    .BR_LEVEL  (5),
    .TMO_CYC   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic trig(input logic x4);
    bus.kmcSETIRQ   = 1'b1;
    bus.kmcVECTXXX4 = x4;
    tick();
    bus.kmcSETIRQ   = 1'b0;
    bus.kmcVECTXXX4 = 1'b0;
  endtask

  task automatic ack();
    bus.devINTA = 1'b1;
    tick();
    bus.devINTA = 1'b0;
  endtask

  initial begin
    bus.kmcINIT     = 1'b0;
    bus.kmcSETIRQ   = 1'b0;
    bus.kmcVECTXXX4 = 1'b0;
    bus.devINTA     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_intr", 16'(bus.devINTR), 16'h0);
    check("rst_vect", bus.devVECT, 16'h0);
    check("rst_vack", 16'(bus.devVACK), 16'h0);
    check("rst_irqo", 16'(bus.kmcIRQO), 16'h0);
    check("rst_tmo", 16'(bus.kmcINTTMO), 16'h0);

    // single base+0 interrupt
    trig(1'b0);
    check("t1_pend_irqo", 16'(bus.kmcIRQO), 16'h1);
    check("t1_pend_intr", 16'(bus.devINTR), 16'h0);
    tick();
    check("t1_intr", 16'(bus.devINTR), 16'h2);
    ack();
    check("t1_vack", 16'(bus.devVACK), 16'h1);
    check("t1_vect", bus.devVECT, 16'o540);
    check("t1_gap_intr", 16'(bus.devINTR), 16'h0);
    tick();
    check("t1_idle_irqo", 16'(bus.kmcIRQO), 16'h0);
    check("t1_idle_vack", 16'(bus.devVACK), 16'h0);
    check("t1_idle_vect", bus.devVECT, 16'h0);

    // base+4 then base+0 pending together: base+0 served first
    trig(1'b1);
    trig(1'b0);
    check("t2_intr", 16'(bus.devINTR), 16'h2);
    ack();
    check("t2_vect_a", bus.devVECT, 16'o540);
    check("t2_gap_intr", 16'(bus.devINTR), 16'h0);
    tick();
    check("t2_rereq", 16'(bus.devINTR), 16'h2);
    check("t2_rereq_vack", 16'(bus.devVACK), 16'h0);
    ack();
    check("t2_vect_b", bus.devVECT, 16'o544);
    check("t2_vack_b", 16'(bus.devVACK), 16'h1);
    tick();
    check("t2_idle_irqo", 16'(bus.kmcIRQO), 16'h0);

    // re-trigger of base+0 coinciding with its acknowledge
    trig(1'b0);
    tick();
    check("t3_intr", 16'(bus.devINTR), 16'h2);
    bus.kmcSETIRQ   = 1'b1;
    bus.kmcVECTXXX4 = 1'b0;
    ack();
    bus.kmcSETIRQ   = 1'b0;
    check("t3_vect", bus.devVECT, 16'o540);
    check("t3_irqo", 16'(bus.kmcIRQO), 16'h1);
    tick();
    check("t3_rereq", 16'(bus.devINTR), 16'h2);
    ack();
    check("t3_vect2", bus.devVECT, 16'o540);
    tick();
    check("t3_idle_irqo", 16'(bus.kmcIRQO), 16'h0);

    // device init while requesting
    trig(1'b1);
    tick();
    check("t4_intr", 16'(bus.devINTR), 16'h2);
    bus.kmcINIT = 1'b1;
    tick();
    bus.kmcINIT = 1'b0;
    check("t4_init_intr", 16'(bus.devINTR), 16'h0);
    check("t4_init_irqo", 16'(bus.kmcIRQO), 16'h0);
    ack();
    check("t4_no_vack", 16'(bus.devVACK), 16'h0);
    check("t4_no_vect", bus.devVECT, 16'h0);
    tick();
    check("t4_still_idle", 16'(bus.devINTR), 16'h0);

    // stray acknowledge in IDLE
    ack();
    check("t5_vack", 16'(bus.devVACK), 16'h0);
    check("t5_vect", bus.devVECT, 16'h0);
    check("t5_irqo", 16'(bus.kmcIRQO), 16'h0);
    tick();
    check("t5_intr", 16'(bus.devINTR), 16'h0);

    // unanswered request
    trig(1'b0);
    tick();
    hiCnt = 0;
    if (bus.devINTR != 4'h0) hiCnt = 1;
`ifdef KMCINTR_TIMEOUT_EN
    for (int i = 0; i < 20 && bus.devINTR != 4'h0; i++) begin
      tick();
      if (bus.devINTR != 4'h0) hiCnt++;
    end
    check("t6_req_cycles", 16'(hiCnt), 16'd8);
    check("t6_tmo", 16'(bus.kmcINTTMO), 16'h1);
    check("t6_irqo", 16'(bus.kmcIRQO), 16'h0);
    tick();
    tick();
    check("t6_tmo_sticky", 16'(bus.kmcINTTMO), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_tmo_clear", 16'(bus.kmcINTTMO), 16'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.devINTR != 4'h0) hiCnt++;
    end
    check("t6_req_held", 16'(hiCnt), 16'd21);
    check("t6_no_tmo", 16'(bus.kmcINTTMO), 16'h0);
    ack();
    check("t6_late_vect", bus.devVECT, 16'o540);
    tick();
    check("t6_idle_irqo", 16'(bus.kmcIRQO), 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
